// File: rtl/traffic_pkg.sv
// Shared definitions for the N-phase traffic controller: state codes and
// the phase selection helpers used by the top-level sequencer.
package traffic_pkg;

  localparam int MAX_PHASE = 32;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ALL_RED = 3'd1,
    ST_GREEN   = 3'd2,
    ST_YELLOW  = 3'd3,
    ST_PREEMPT = 3'd4
  } state_e;

  function automatic logic [MAX_PHASE-1:0] onehot(input int idx);
    logic [MAX_PHASE-1:0] one;
    logic [4:0]           sh;
    one = 32'd1;
    sh  = idx[4:0];
    return one << sh;
  endfunction

  // First phase after cur (wrapping, cur itself last) with demand; with no
  // demand anywhere the controller simply steps to the following phase.
  function automatic int next_phase(input logic [MAX_PHASE-1:0] car,
                                    input int cur, input int n);
    int   res;
    int   q;
    logic found;
    res   = (cur + 1) % n;
    found = 1'b0;
    for (int k = 1; k <= MAX_PHASE; k++) begin
      if (!found && k <= n) begin
        q = (cur + k) % n;
        if (car[q[4:0]]) begin
          res   = q;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control inputs and lamp/status outputs of one intersection controller.
interface traffic_phase_ctrl_if #(
  parameter int N_PHASE = 4,
  parameter int TW      = 8
);
  localparam int PW = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;

  logic               Online;
  logic               Police;
  logic               Peaks;
  logic [N_PHASE-1:0] Car;
  logic [TW-1:0]      green_base;
  logic [TW-1:0]      peak_extra;
  logic [N_PHASE-1:0] green;
  logic [N_PHASE-1:0] yellow;
  logic [N_PHASE-1:0] red;
  logic [PW-1:0]      phase;
  logic [2:0]         state;
  logic [TW-1:0]      remain;

  modport master (
    output Online, Police, Peaks, Car, green_base, peak_extra,
    input  green, yellow, red, phase, state, remain
  );

  modport slave (
    input  Online, Police, Peaks, Car, green_base, peak_extra,
    output green, yellow, red, phase, state, remain
  );
endinterface

// File: rtl/tick_gen.sv
// Timing-tick prescaler: one-cycle pulse every TICK_DIV clocks (every
// cycle when TICK_DIV is 1).
module tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == LAST) ? '0 : div_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  assign tick_o = (div_q == LAST);
endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase signal sequencer: green/yellow/all-red rotation with demand skip,
// peak extension, gap-out, police preemption and offline flashing.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_PHASE   = 4,
  parameter int TW        = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int MIN_GREEN = 4,
  parameter int TICK_DIV  = 1
) (
  input logic                 clk,
  input logic                 Reset,
  traffic_phase_ctrl_if.slave bus
);
  localparam int            PW      = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
  localparam logic [TW-1:0] YEL_LD  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALR_LD  = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] MING_TH = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] CNT_MAX = '1;

  logic tick;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] el_q, el_d;
  logic          flash_q, flash_d;

  logic [TW:0]          peakSum;
  logic [TW-1:0]        greenLen;
  logic [MAX_PHASE-1:0] curOh;
  logic [N_PHASE-1:0]   curMask;
  logic                 gapOut;
  int                   nextRaw;
  logic [PW-1:0]        nextPhase;
  logic [N_PHASE-1:0]   greenL, yellowL, redL;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (Reset),
    .tick_o(tick)
  );

  // Green length for the upcoming interval: peak sum saturates at 2^TW-1,
  // and a zero length is stretched to one tick.
  always_comb begin
    peakSum = {1'b0, bus.green_base} + {1'b0, bus.peak_extra};
    if (!bus.Peaks)      greenLen = bus.green_base;
    else if (peakSum[TW]) greenLen = CNT_MAX;
    else                 greenLen = peakSum[TW-1:0];
    if (greenLen == '0) greenLen = TW'(1);
  end

  always_comb begin
    curOh     = onehot(int'(phase_q));
    curMask   = curOh[N_PHASE-1:0];
    gapOut    = (el_q >= MING_TH) && !bus.Car[phase_q] &&
                (|(bus.Car & ~curMask));
    nextRaw   = next_phase(MAX_PHASE'(bus.Car), int'(phase_q), N_PHASE);
    nextPhase = nextRaw[PW-1:0];
  end

  // Offline mode overrides everything and bypasses the tick; all other
  // transitions wait for a tick.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    el_d    = el_q;
    flash_d = flash_q;
    if (!bus.Online) begin
      state_d = ST_OFF;
      if (state_q == ST_OFF && tick) flash_d = ~flash_q;
    end else if (state_q == ST_OFF) begin
      state_d = ST_ALL_RED;
      cnt_d   = ALR_LD;
    end else if (tick) begin
      unique case (state_q)
        ST_ALL_RED: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
          end else if (bus.Police) begin
            state_d = ST_PREEMPT;
            cnt_d   = '0;
          end else begin
            state_d = ST_GREEN;
            phase_d = nextPhase;
            cnt_d   = greenLen - TW'(1);
            el_d    = '0;
          end
        end
        ST_GREEN: begin
          if (el_q != CNT_MAX) el_d = el_q + TW'(1);
          if (cnt_q == '0 || gapOut || bus.Police) begin
            state_d = ST_YELLOW;
            cnt_d   = YEL_LD;
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        ST_YELLOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
          end else begin
            state_d = ST_ALL_RED;
            cnt_d   = ALR_LD;
          end
        end
        ST_PREEMPT: begin
          if (!bus.Police) begin
            state_d = ST_ALL_RED;
            cnt_d   = ALR_LD;
          end
        end
        default: begin
          state_d = ST_ALL_RED;
          cnt_d   = ALR_LD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_ALL_RED;
      phase_q <= PW'(N_PHASE - 1);
      cnt_q   <= ALR_LD;
      el_q    <= '0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      el_q    <= el_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    greenL  = '0;
    yellowL = '0;
    redL    = '1;
    unique case (state_q)
      ST_OFF: begin
        yellowL = {N_PHASE{flash_q}};
        redL    = '0;
      end
      ST_GREEN: begin
        greenL = curMask;
        redL   = ~curMask;
      end
      ST_YELLOW: begin
        yellowL = curMask;
        redL    = ~curMask;
      end
      default: begin
        redL = '1;
      end
    endcase
  end

  assign bus.green  = greenL;
  assign bus.yellow = yellowL;
  assign bus.red    = redL;
  assign bus.phase  = phase_q;
  assign bus.state  = state_q;
  assign bus.remain = cnt_q;

  aLampExclusive : assert property (@(posedge clk) disable iff (Reset)
    (state_q != ST_OFF) |-> ($countones(greenL | yellowL) <= 1));
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: per-cycle expected lamps and
// state queued by the driver and compared by a monitor on the falling edge.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int NP  = 4;
  localparam int TWB = 8;

  logic clk   = 1'b0;
  logic Reset = 1'b1;

  traffic_phase_ctrl_if #(.N_PHASE(NP), .TW(TWB)) bus ();

  traffic_phase_ctrl #(
    .N_PHASE  (NP),
    .TW       (TWB),
    .YELLOW_T (3),
    .ALLRED_T (2),
    .MIN_GREEN(4),
    .TICK_DIV (1)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       online;
    logic       police;
    logic       peaks;
    logic [3:0] car;
    logic [7:0] extra;
    logic [7:0] base;
    logic [2:0] st;
    logic [1:0] ph;
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    int         reps;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic [1:0] ph;
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic       chkRem;
    logic [7:0] rem;
    int         seq;
  } exp_t;

  exp_t sbQ[$];
  vec_t tbl[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycleNo    = 0;

  // Expected lamps follow directly from the expected state and phase.
  function automatic vec_t mk(input logic rst, input logic online,
                              input logic police, input logic peaks,
                              input logic [3:0] car, input logic [7:0] extra,
                              input logic [2:0] st, input logic [1:0] ph,
                              input logic [3:0] offY, input int reps);
    vec_t       v;
    logic [3:0] oh;
    oh       = 4'b0001 << ph;
    v.rst    = rst;
    v.online = online;
    v.police = police;
    v.peaks  = peaks;
    v.car    = car;
    v.extra  = extra;
    v.base   = 8'd10;
    v.st     = st;
    v.ph     = ph;
    v.reps   = reps;
    v.g      = 4'b0000;
    v.y      = 4'b0000;
    v.r      = 4'b1111;
    if (st == 3'd2) begin v.g = oh; v.r = ~oh; end
    if (st == 3'd3) begin v.y = oh; v.r = ~oh; end
    if (st == 3'd0) begin v.y = offY; v.r = 4'b0000; end
    return v;
  endfunction

  task automatic chk(input string nm, input int seq,
                     input logic [7:0] act, input logic [7:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h, want %0h", nm, seq, act, expv);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic chkR,
                               input logic [7:0] rem);
    exp_t e;
    @(posedge clk);
    #1;
    Reset          = v.rst;
    bus.Online     = v.online;
    bus.Police     = v.police;
    bus.Peaks      = v.peaks;
    bus.Car        = v.car;
    bus.peak_extra = v.extra;
    bus.green_base = v.base;
    e.st     = v.st;
    e.ph     = v.ph;
    e.g      = v.g;
    e.y      = v.y;
    e.r      = v.r;
    e.chkRem = chkR;
    e.rem    = rem;
    e.seq    = cycleNo;
    sbQ.push_back(e);
    cycleNo++;
  endtask

  task automatic checkOutput(input exp_t e);
    chk("state",  e.seq, 8'(bus.state),  8'(e.st));
    chk("phase",  e.seq, 8'(bus.phase),  8'(e.ph));
    chk("green",  e.seq, 8'(bus.green),  8'(e.g));
    chk("yellow", e.seq, 8'(bus.yellow), 8'(e.y));
    chk("red",    e.seq, 8'(bus.red),    8'(e.r));
    if (e.chkRem) chk("remain", e.seq, bus.remain, e.rem);
    if (e.st != 3'd0)
      chk("lamp_exclusive", e.seq,
          8'($countones(bus.green | bus.yellow) <= 1), 8'd1);
  endtask

  task automatic runRem(input vec_t v, input logic [7:0] start);
    for (int k = 0; k < v.reps; k++) applyStimulus(v, 1'b1, start - 8'(k));
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  initial begin
    vec_t hv;
    bus.Online     = 1'b1;
    bus.Police     = 1'b0;
    bus.Peaks      = 1'b0;
    bus.Car        = 4'b1111;
    bus.green_base = 8'd10;
    bus.peak_extra = 8'd0;

    // basic rotation with demand everywhere
    tbl.push_back(mk(1, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd0, 0, 10));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_YELLOW,  2'd0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd1, 0, 10));
    // demand only on phases 0 and 3
    tbl.push_back(mk(1, 1, 0, 0, 4'b1001, 0, ST_ALL_RED, 2'd3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1001, 0, ST_ALL_RED, 2'd3, 0, 2));
    for (int c = 0; c < 2; c++) begin
      tbl.push_back(mk(0, 1, 0, 0, 4'b1001, 0, ST_GREEN,   2'd0, 0, 10));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1001, 0, ST_YELLOW,  2'd0, 0, 3));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1001, 0, ST_ALL_RED, 2'd0, 0, 2));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1001, 0, ST_GREEN,   2'd3, 0, 10));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1001, 0, ST_YELLOW,  2'd3, 0, 3));
      tbl.push_back(mk(0, 1, 0, 0, 4'b1001, 0, ST_ALL_RED, 2'd3, 0, 2));
    end
    // peak extension: saturated, then unsaturated
    tbl.push_back(mk(1, 1, 0, 1, 4'b1111, 8'd250, ST_ALL_RED, 2'd3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 4'b1111, 8'd250, ST_ALL_RED, 2'd3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1, 4'b1111, 8'd250, ST_GREEN,   2'd0, 0, 255));
    tbl.push_back(mk(0, 1, 0, 1, 4'b1111, 8'd5,   ST_YELLOW,  2'd0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 1, 4'b1111, 8'd5,   ST_ALL_RED, 2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1, 4'b1111, 8'd5,   ST_GREEN,   2'd1, 0, 15));
    tbl.push_back(mk(0, 1, 0, 1, 4'b1111, 8'd5,   ST_YELLOW,  2'd1, 0, 1));
    // gap-out after minimum green
    tbl.push_back(mk(1, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 0, ST_GREEN,   2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 0, ST_YELLOW,  2'd0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 0, ST_ALL_RED, 2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0100, 0, ST_GREEN,   2'd2, 0, 2));
    // police preemption
    tbl.push_back(mk(1, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd0, 0, 4));
    tbl.push_back(mk(0, 1, 1, 0, 4'b1111, 0, ST_GREEN,   2'd0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 4'b1111, 0, ST_YELLOW,  2'd0, 0, 3));
    tbl.push_back(mk(0, 1, 1, 0, 4'b1111, 0, ST_ALL_RED, 2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 1, 0, 4'b1111, 0, ST_PREEMPT, 2'd0, 0, 4));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_PREEMPT, 2'd0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd1, 0, 2));
    // offline flashing, return to service, async reset during yellow
    tbl.push_back(mk(1, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'b1111, 0, ST_GREEN,   2'd0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'b1111, 0, ST_OFF,     2'd0, 4'b0000, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'b1111, 0, ST_OFF,     2'd0, 4'b1111, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'b1111, 0, ST_OFF,     2'd0, 4'b0000, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_OFF,     2'd0, 4'b1111, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd1, 0, 10));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_YELLOW,  2'd1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd0, 0, 1));
    // lost demand with nobody else waiting: no gap-out, then plain step
    tbl.push_back(mk(1, 1, 0, 0, 4'b0001, 0, ST_ALL_RED, 2'd3, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0001, 0, ST_ALL_RED, 2'd3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0001, 0, ST_GREEN,   2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, ST_GREEN,   2'd0, 0, 8));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, ST_YELLOW,  2'd0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, ST_ALL_RED, 2'd0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, ST_GREEN,   2'd1, 0, 1));

    for (int i = 0; i < tbl.size(); i++)
      for (int k = 0; k < tbl[i].reps; k++) applyStimulus(tbl[i], 1'b0, 8'd0);

    // countdown values through reset, all-red, green and yellow
    runRem(mk(1, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 1), 8'd1);
    runRem(mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 2), 8'd1);
    runRem(mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN,   2'd0, 0, 10), 8'd9);
    runRem(mk(0, 1, 0, 0, 4'b1111, 0, ST_YELLOW,  2'd0, 0, 3), 8'd2);

    // zero green_base behaves as a one-tick green
    runRem(mk(1, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 1), 8'd1);
    hv = mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd3, 0, 2);
    hv.base = 8'd0;
    runRem(hv, 8'd1);
    hv = mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN, 2'd0, 0, 1);
    hv.base = 8'd0;
    runRem(hv, 8'd0);
    hv = mk(0, 1, 0, 0, 4'b1111, 0, ST_YELLOW, 2'd0, 0, 3);
    hv.base = 8'd0;
    runRem(hv, 8'd2);
    hv = mk(0, 1, 0, 0, 4'b1111, 0, ST_ALL_RED, 2'd0, 0, 2);
    hv.base = 8'd0;
    runRem(hv, 8'd1);
    hv = mk(0, 1, 0, 0, 4'b1111, 0, ST_GREEN, 2'd1, 0, 1);
    hv.base = 8'd0;
    runRem(hv, 8'd0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", cycleNo, 8'(sbQ.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-phase traffic-signal controller, the next generation of the two-road `maincontrol` intersection controller. It sequences green, yellow and all-red intervals across `N_PHASE` approaches and skips phases that have no demand. It also provides peak-hour green extension, gap-out on lost demand, police preemption and an offline flashing mode. It drives the lamp outputs and the countdown display of one intersection.

## Interface
- `N_PHASE`, 4: number of signal phases (≥2)
- `TW`, 8: timer/countdown width
- `YELLOW_T`, 3: yellow duration, ticks (≥1)
- `ALLRED_T`, 2: all-red clearance duration, ticks (≥1)
- `MIN_GREEN`, 4: minimum green before gap-out, ticks (≥1)
- `TICK_DIV`, 1: clk cycles per timing tick (≥1)

- `clk`  in  1  system clock
- `Reset`  in  1  asynchronous, active-high reset
- `Online`  in  1  1 = normal operation; 0 = offline flashing
- `Police`  in  1  level preemption request; sampled on ticks
- `Peaks`  in  1  peak mode; extends green
- `Car`  in  N_PHASE  per-phase vehicle demand
- `green_base`  in  TW  normal green duration, ticks (0 treated as 1)
- `peak_extra`  in  TW  added green in peak mode
- `green`, `yellow`, `red`  out  N_PHASE  lamp drives, one bit per phase
- `phase`  out  max(1,$clog2(N_PHASE))  current phase index
- `state`  out  3  controller state code
- `remain`  out  TW  ticks left in the current interval, minus one

## Operation
- **States:** OFF, ALL_RED, GREEN, YELLOW, PREEMPT.
- **Reset values:**
  - state=ALL_RED, `phase`=N_PHASE-1, cnt=ALLRED_T-1, el=0, flash=0, prescaler=0.
  - `red`=all 1, `green`=0, `yellow`=0.
- **Duration rule:**
  - Entering an interval of D ticks loads cnt=D-1.
  - On each tick: if cnt≠0, decrement cnt; else take the exit transition.
  - `remain`=cnt.
- **Next-phase select:**
  - The next phase is the first q in `phase`+1 … `phase`+N_PHASE (mod N_PHASE) with `Car[q]`=1.
  - If no phase has demand, the next phase is (`phase`+1) mod N_PHASE.
- **GREEN:**
  - Entry loads cnt=G-1 and el=0.
  - G = `green_base` when Peaks=0.
  - G = min(`green_base`+`peak_extra`, 2^TW-1) when Peaks=1; the sum is computed in TW+1 bits and saturates.
  - Peaks is sampled only at GREEN entry.
  - el increments on each tick and saturates.
- **GREEN exits to YELLOW on a tick when any of these holds:**
  - cnt=0;
  - gap-out: el ≥ MIN_GREEN-1, `Car[phase]`=0, and any other `Car` bit is 1;
  - Police=1 (immediate; ignores MIN_GREEN).
- **YELLOW:** lasts YELLOW_T ticks and is never shortened; exits to ALL_RED.
- **ALL_RED:**
  - Lasts ALLRED_T ticks.
  - On exit: if Police=1, go to PREEMPT; otherwise go to GREEN and set `phase` = next phase.
- **PREEMPT:** all red; held while Police=1; on the tick where Police=0, go to ALL_RED.
- **OFF:**
  - `Online`=0 forces OFF on the next clk from any state, regardless of tick. `Online` dominates Police.
  - In OFF, flash toggles every tick; `yellow`={N{flash}}; red=0; green=0.
  - When `Online`=1, the next clk enters ALL_RED with cnt=ALLRED_T-1 and `phase` unchanged.
- **Lamp decode:** combinational from registered state/phase.
  - GREEN: `green`=onehot(`phase`), other phases red.
  - YELLOW: `yellow`=onehot(`phase`), other phases red.
  - ALL_RED and PREEMPT: all red.
- **Invariant:** at most one `green` or `yellow` bit is set outside OFF.
- **State codes:** OFF=0, ALL_RED=1, GREEN=2, YELLOW=3, PREEMPT=4.

## Timing
- The tick is a single-cycle pulse every TICK_DIV clk cycles; with TICK_DIV=1 it is asserted every cycle.
- All transitions except entry to and exit from OFF occur on the clk edge where tick=1.
- An interval of D ticks shows its lamps for exactly D×TICK_DIV cycles.
- `Online` falling: OFF lamps appear one cycle later.
- Police edge: sampled on the next tick; a pulse shorter than TICK_DIV may be missed.
- Reset asserted mid-interval: outputs take reset values immediately and asynchronously; the first green after release is phase 0 (given demand on phase 0 or none anywhere).

## Structure
- Shared package `traffic_pkg`: state enum and its codes, the onehot helper function, and the next-phase priority function.
- Sub-module `tick_gen`: TICK_DIV prescaler producing the `tick` pulse, reset to 0.
- Top-level module: state machine, timers, lamp decode.

## Test plan
All scenarios use N_PHASE=4, TW=8, YELLOW_T=3, ALLRED_T=2, MIN_GREEN=4, TICK_DIV=1, green_base=10.
1. Reset, Car=4'b1111, Online=1 -> red=1111 for 2 cycles; green=0001 for 10; yellow=0001 for 3; all red for 2; then green=0010.
2. Car=4'b1001 -> phase order 0,3,0,3; phases 1 and 2 are never green.
3. Peaks=1, peak_extra=250 -> green lasts 255 cycles (saturated); with peak_extra=5 it lasts 15 cycles.
4. Phase 0 green, Car drops to 4'b0100 after green cycle 2 -> yellow begins after green cycle 4; next green is phase 2.
5. Police=1 at green cycle 5 -> yellow on the next cycle for 3, all-red for 2, PREEMPT while held; on release, 2 all-red then next-phase green.
6. Online=0 mid-green -> next cycle red=0, green=0, yellow toggles 1111/0000 each cycle. Reset pulsed during yellow -> immediately red=1111, state=1.
